// File: rtl/render_pkg.sv
// Shared rendering constants and the animation sequencer state type for the
// VGA sprite path.
package render_pkg;

   localparam int COLOR_W = 12;
   localparam int COORD_W = 10;

   localparam logic [COLOR_W-1:0] BLACK       = 12'h000;
   localparam logic [COLOR_W-1:0] TRANSPARENT = 12'hF0F;
   localparam logic [COLOR_W-1:0] BG_COLOR    = 12'h000;

   typedef enum logic {
      IDLE,
      PLAY
   } anim_state_t;

endpackage

// File: rtl/sprite_anim_seq.sv
// Per-layer animation frame sequencer: free-running loop mode or triggered
// one-shot mode with a busy flag and a completion pulse.
module sprite_anim_seq
   import render_pkg::*;
#(
   parameter int FRAME_W = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic               en,
   input  logic               oneshot,
   input  logic               start,
   input  logic [FRAME_W-1:0] last,
   output logic [FRAME_W-1:0] frame,
   output logic               busy,
   output logic               done
);

   anim_state_t        state, state_n;
   logic [FRAME_W-1:0] frame_n;
   logic               done_n;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         frame <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         frame <= frame_n;
         done  <= done_n;
      end
   end

   // Priority: disable, then mode, then start, then tick.
   always_comb begin
      state_n = state;
      frame_n = frame;
      done_n  = 1'b0;
      if (!en) begin
         state_n = IDLE;
         frame_n = '0;
      end else if (!oneshot) begin
         if (state == PLAY) begin
            state_n = IDLE;
            frame_n = '0;
         end else if (tick) begin
            frame_n = (frame >= last) ? '0 : frame + 1'b1;
         end
      end else if (start) begin
         state_n = PLAY;
         frame_n = '0;
      end else if (state == PLAY) begin
         if (tick) begin
            if (frame < last) begin
               frame_n = frame + 1'b1;
            end else begin
               state_n = IDLE;
               frame_n = '0;
               done_n  = 1'b1;
            end
         end
      end else begin
         frame_n = '0;
      end
   end

   assign busy = (state == PLAY);

endmodule

// File: rtl/sprite_compositor.sv
// N-layer sprite compositor: box hit test and ROM addressing, one pipeline
// stage aligned with ROM data, then priority/colour-key merge into rgb.
module sprite_compositor #(
   parameter int                   NUM_LAYERS  = 4,
   parameter int                   COLOR_W     = render_pkg::COLOR_W,
   parameter int                   COORD_W     = render_pkg::COORD_W,
   parameter int                   FRAME_W     = 2,
   parameter logic [COLOR_W-1:0]   TRANSPARENT = render_pkg::TRANSPARENT,
   parameter logic [COLOR_W-1:0]   BG_COLOR    = render_pkg::BG_COLOR
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            tick,
   input  logic                            bright,
   input  logic [COORD_W-1:0]              h_count,
   input  logic [COORD_W-1:0]              v_count,
   input  logic [NUM_LAYERS-1:0]           layer_en,
   input  logic [NUM_LAYERS*COORD_W-1:0]   layer_x,
   input  logic [NUM_LAYERS*COORD_W-1:0]   layer_y,
   input  logic [NUM_LAYERS*COORD_W-1:0]   layer_w,
   input  logic [NUM_LAYERS*COORD_W-1:0]   layer_h,
   input  logic [NUM_LAYERS*FRAME_W-1:0]   layer_last,
   input  logic [NUM_LAYERS-1:0]           layer_oneshot,
   input  logic [NUM_LAYERS-1:0]           anim_start,
   output logic [NUM_LAYERS*COORD_W-1:0]   rom_row,
   output logic [NUM_LAYERS*COORD_W-1:0]   rom_col,
   output logic [NUM_LAYERS*FRAME_W-1:0]   rom_frame,
   input  logic [NUM_LAYERS*COLOR_W-1:0]   rom_data,
   output logic [NUM_LAYERS-1:0]           anim_busy,
   output logic [NUM_LAYERS-1:0]           anim_done,
   output logic [COLOR_W-1:0]              rgb
);

   import render_pkg::*;

   logic [NUM_LAYERS-1:0] hit_p0;
   logic [NUM_LAYERS-1:0] hit_p1;
   logic                  bright_p1;
   logic [COLOR_W-1:0]    pix_sel_p1;

   // One extra bit keeps lo+len from wrapping at the right/bottom edge.
   function automatic logic span_hit(input logic [COORD_W-1:0] pos,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] len);
      return ({1'b0, pos} >= {1'b0, lo}) &&
             ({1'b0, pos} <  ({1'b0, lo} + {1'b0, len}));
   endfunction

   for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
      assign rom_row[g*COORD_W +: COORD_W] = v_count - layer_y[g*COORD_W +: COORD_W];
      assign rom_col[g*COORD_W +: COORD_W] = h_count - layer_x[g*COORD_W +: COORD_W];

      assign hit_p0[g] = layer_en[g] &&
                         span_hit(h_count, layer_x[g*COORD_W +: COORD_W],
                                  layer_w[g*COORD_W +: COORD_W]) &&
                         span_hit(v_count, layer_y[g*COORD_W +: COORD_W],
                                  layer_h[g*COORD_W +: COORD_W]);

      sprite_anim_seq #(
         .FRAME_W (FRAME_W)
      ) u_seq (
         .clk     (clk),
         .reset   (reset),
         .tick    (tick),
         .en      (layer_en[g]),
         .oneshot (layer_oneshot[g]),
         .start   (anim_start[g]),
         .last    (layer_last[g*FRAME_W +: FRAME_W]),
         .frame   (rom_frame[g*FRAME_W +: FRAME_W]),
         .busy    (anim_busy[g]),
         .done    (anim_done[g])
      );
   end

   // ---- stage p0 -> p1: hit flags and blanking, aligned with rom_data
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hit_p1    <= '0;
         bright_p1 <= 1'b0;
      end else begin
         hit_p1    <= hit_p0;
         bright_p1 <= bright;
      end
   end

   // Scan from the lowest priority upward so the lowest index wins.
   always_comb begin
      pix_sel_p1 = BG_COLOR;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (hit_p1[i] && (rom_data[i*COLOR_W +: COLOR_W] != TRANSPARENT)) begin
            pix_sel_p1 = rom_data[i*COLOR_W +: COLOR_W];
         end
      end
   end

   // ---- stage p1 -> p2: registered output colour
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rgb <= BLACK;
      end else begin
         rgb <= bright_p1 ? pix_sel_p1 : BLACK;
      end
   end

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: ROM emulation, a spec-level reference model
// compared every cycle, and directed scenarios with literal expectations.
module tb_sprite_compositor;

   localparam int N  = 4;
   localparam int CW = 12;
   localparam int XW = 10;
   localparam int FW = 2;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            tick = 1'b0;
   logic            bright = 1'b0;
   logic [XW-1:0]   h_count = '0;
   logic [XW-1:0]   v_count = '0;
   logic [N-1:0]    layer_en = '0;
   logic [N-1:0]    layer_oneshot = '0;
   logic [N-1:0]    anim_start = '0;

   logic [XW-1:0]   lx [N];
   logic [XW-1:0]   ly [N];
   logic [XW-1:0]   lw [N];
   logic [XW-1:0]   lh [N];
   logic [FW-1:0]   llast [N];
   logic [CW-1:0]   base [N];
   int              key_col [N];
   int              key_row [N];

   logic [N*XW-1:0] layer_x, layer_y, layer_w, layer_h;
   logic [N*FW-1:0] layer_last;
   logic [N*XW-1:0] rom_row, rom_col;
   logic [N*FW-1:0] rom_frame;
   logic [N*CW-1:0] rom_data = '0;
   logic [N-1:0]    anim_busy, anim_done;
   logic [CW-1:0]   rgb;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         layer_x[i*XW +: XW]    = lx[i];
         layer_y[i*XW +: XW]    = ly[i];
         layer_w[i*XW +: XW]    = lw[i];
         layer_h[i*XW +: XW]    = lh[i];
         layer_last[i*FW +: FW] = llast[i];
      end
   end

   sprite_compositor dut (
      .clk           (clk),
      .reset         (reset),
      .tick          (tick),
      .bright        (bright),
      .h_count       (h_count),
      .v_count       (v_count),
      .layer_en      (layer_en),
      .layer_x       (layer_x),
      .layer_y       (layer_y),
      .layer_w       (layer_w),
      .layer_h       (layer_h),
      .layer_last    (layer_last),
      .layer_oneshot (layer_oneshot),
      .anim_start    (anim_start),
      .rom_row       (rom_row),
      .rom_col       (rom_col),
      .rom_frame     (rom_frame),
      .rom_data      (rom_data),
      .anim_busy     (anim_busy),
      .anim_done     (anim_done),
      .rgb           (rgb)
   );

   // Sprite image: flat colour per layer, with an optional transparent row/column.
   function automatic logic [CW-1:0] pix(input int i, input logic [XW-1:0] row,
                                         input logic [XW-1:0] col);
      if (int'(col) == key_col[i] || int'(row) == key_row[i]) return 12'hF0F;
      return base[i];
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < N; i++)
         rom_data[i*CW +: CW] <= pix(i, rom_row[i*XW +: XW], rom_col[i*XW +: XW]);
   end

   // Colour the screen must show for one pixel, straight from the layer rules.
   function automatic logic [CW-1:0] model_pix(input int h, input int v,
                                               input logic br, input logic [N-1:0] en);
      if (!br) return 12'h000;
      for (int i = 0; i < N; i++) begin
         if (en[i] && h >= int'(lx[i]) && h < int'(lx[i]) + int'(lw[i]) &&
             v >= int'(ly[i]) && v < int'(ly[i]) + int'(lh[i])) begin
            logic [CW-1:0] p;
            p = pix(i, XW'(v - int'(ly[i])), XW'(h - int'(lx[i])));
            if (p != 12'hF0F) return p;
         end
      end
      return 12'h000;
   endfunction

   logic [CW-1:0] exp_rgb  = '0;
   logic [CW-1:0] pend_rgb = '0;
   int            mframe [N];
   bit            mplay  [N];
   bit            mdone  [N];

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         exp_rgb  = '0;
         pend_rgb = '0;
         for (int i = 0; i < N; i++) begin
            mframe[i] = 0;
            mplay[i]  = 0;
            mdone[i]  = 0;
         end
      end else begin
         exp_rgb  = pend_rgb;
         pend_rgb = model_pix(int'(h_count), int'(v_count), bright, layer_en);
         for (int i = 0; i < N; i++) begin
            mdone[i] = 0;
            if (!layer_en[i]) begin
               mplay[i] = 0; mframe[i] = 0;
            end else if (!layer_oneshot[i]) begin
               if (mplay[i]) begin
                  mplay[i] = 0; mframe[i] = 0;
               end else if (tick) begin
                  mframe[i] = (mframe[i] >= int'(llast[i])) ? 0 : mframe[i] + 1;
               end
            end else if (anim_start[i]) begin
               mplay[i] = 1; mframe[i] = 0;
            end else if (!mplay[i]) begin
               mframe[i] = 0;
            end else if (tick) begin
               if (mframe[i] < int'(llast[i])) mframe[i] = mframe[i] + 1;
               else begin
                  mplay[i] = 0; mframe[i] = 0; mdone[i] = 1;
               end
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("model_rgb", int'(rgb), int'(exp_rgb));
      for (int i = 0; i < N; i++) begin
         logic [XW-1:0] er, ec;
         er = v_count - ly[i];
         ec = h_count - lx[i];
         check("model_rom_row", int'(rom_row[i*XW +: XW]), int'(er));
         check("model_rom_col", int'(rom_col[i*XW +: XW]), int'(ec));
         check("model_frame", int'(rom_frame[i*FW +: FW]), mframe[i]);
         check("model_busy", int'(anim_busy[i]), int'(mplay[i]));
         check("model_done", int'(anim_done[i]), int'(mdone[i]));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   int            bh [4]  = '{319, 320, 383, 384};
   int            bcol [4] = '{1023, 0, 63, 64};
   logic [CW-1:0] brgb [4] = '{12'h000, 12'h00F, 12'h00F, 12'h000};
   int            loop_exp [6] = '{1, 2, 0, 1, 2, 0};

   initial begin
      for (int i = 0; i < N; i++) begin
         lx[i] = '0; ly[i] = '0; lw[i] = '0; lh[i] = '0;
         llast[i] = '0; base[i] = '0; key_col[i] = -1; key_row[i] = -1;
      end
      lx[0] = 10'd90;  ly[0] = 10'd90;  lw[0] = 10'd20; lh[0] = 10'd20;  base[0] = 12'hF00; llast[0] = 2'd3;
      lx[1] = 10'd95;  ly[1] = 10'd95;  lw[1] = 10'd20; lh[1] = 10'd20;  base[1] = 12'h0F0; llast[1] = 2'd1;
      lx[2] = 10'd320; ly[2] = 10'd0;   lw[2] = 10'd64; lh[2] = 10'd480; base[2] = 12'h00F; llast[2] = 2'd0;
      lx[3] = 10'd600; ly[3] = 10'd400; lw[3] = 10'd16; lh[3] = 10'd16;  base[3] = 12'h888; llast[3] = 2'd2;
      layer_oneshot = 4'b0010;

      cyc(2);
      check("reset_rgb", int'(rgb), 0);
      check("reset_busy", int'(anim_busy), 0);
      check("reset_frame", int'(rom_frame), 0);
      reset = 1'b1;

      // Priority, enable, colour key, background and blanking.
      layer_en = 4'b0011; h_count = 10'd100; v_count = 10'd100; bright = 1'b1;
      cyc(2); check("overlap_l0", int'(rgb), 12'hF00);
      layer_en = 4'b0010;
      cyc(2); check("l0_disabled", int'(rgb), 12'h0F0);
      layer_en = 4'b0011; key_col[0] = 10;
      cyc(2); check("l0_transparent", int'(rgb), 12'h0F0);
      key_col[0] = -1; h_count = 10'd500;
      cyc(2); check("background", int'(rgb), 12'h000);
      h_count = 10'd100; bright = 1'b0;
      cyc(2); check("blanked", int'(rgb), 12'h000);
      bright = 1'b1;
      cyc(1); check("latency_1", int'(rgb), 12'h000);
      cyc(1); check("latency_2", int'(rgb), 12'hF00);

      // Horizontal box edges of layer 2.
      layer_en = 4'b0100; v_count = 10'd10;
      for (int k = 0; k < 4; k++) begin
         h_count = XW'(bh[k]);
         #1 check("edge_rom_col", int'(rom_col[2*XW +: XW]), bcol[k]);
         cyc(2); check("edge_rgb", int'(rgb), int'(brgb[k]));
      end
      lw[2] = 10'd0; h_count = 10'd320;
      cyc(2); check("zero_width", int'(rgb), 12'h000);
      lw[2] = 10'd64;

      // Loop mode on layer 3.
      layer_en = 4'b1111; h_count = 10'd500;
      for (int k = 0; k < 6; k++) begin
         tick = 1'b1; cyc(1); tick = 1'b0;
         check("loop_frame", int'(rom_frame[3*FW +: FW]), loop_exp[k]);
         cyc(1);
      end

      // One-shot on layer 1 (last = 1).
      check("os_idle_busy", int'(anim_busy[1]), 0);
      anim_start = 4'b0010; cyc(1); anim_start = '0;
      check("os_busy_rise", int'(anim_busy[1]), 1);
      check("os_frame0", int'(rom_frame[1*FW +: FW]), 0);
      tick = 1'b1; cyc(1); tick = 1'b0;
      check("os_frame1", int'(rom_frame[1*FW +: FW]), 1);
      check("os_no_done", int'(anim_done[1]), 0);
      tick = 1'b1; cyc(1); tick = 1'b0;
      check("os_done", int'(anim_done[1]), 1);
      check("os_busy_fall", int'(anim_busy[1]), 0);
      check("os_frame_end", int'(rom_frame[1*FW +: FW]), 0);
      cyc(1); check("os_done_pulse", int'(anim_done[1]), 0);
      anim_start = 4'b0010; cyc(1); anim_start = '0;
      tick = 1'b1; cyc(1); tick = 1'b0;
      anim_start = 4'b0010; cyc(1); anim_start = '0;
      check("restart_frame", int'(rom_frame[1*FW +: FW]), 0);
      check("restart_busy", int'(anim_busy[1]), 1);
      check("restart_no_done", int'(anim_done[1]), 0);
      tick = 1'b1; cyc(1); tick = 1'b0;
      anim_start = 4'b0010; tick = 1'b1; cyc(1); anim_start = '0; tick = 1'b0;
      check("start_tick_frame", int'(rom_frame[1*FW +: FW]), 0);
      check("start_tick_busy", int'(anim_busy[1]), 1);

      // Mode change and disable mid-sequence.
      tick = 1'b1; cyc(1); tick = 1'b0;
      layer_oneshot = 4'b0000; cyc(1);
      check("mode_chg_frame", int'(rom_frame[1*FW +: FW]), 0);
      check("mode_chg_busy", int'(anim_busy[1]), 0);
      layer_oneshot = 4'b0010; cyc(1);
      anim_start = 4'b0010; cyc(1); anim_start = '0;
      layer_en = 4'b1101; cyc(1);
      check("disable_busy", int'(anim_busy[1]), 0);
      check("disable_done", int'(anim_done[1]), 0);
      layer_en = 4'b1111;

      // Asynchronous reset while layer 1 plays frame 2.
      llast[1] = 2'd3; h_count = 10'd100; v_count = 10'd100;
      anim_start = 4'b0010; cyc(1); anim_start = '0;
      tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
      tick = 1'b1; cyc(1); tick = 1'b0;
      check("pre_reset_frame", int'(rom_frame[1*FW +: FW]), 2);
      check("pre_reset_rgb", int'(rgb), 12'hF00);
      reset = 1'b0;
      #1;
      check("async_rgb", int'(rgb), 0);
      check("async_busy", int'(anim_busy[1]), 0);
      check("async_frame", int'(rom_frame[1*FW +: FW]), 0);
      cyc(2);
      reset = 1'b1;
      cyc(2);
      check("recover_rgb", int'(rgb), 12'hF00);
      check("recover_busy", int'(anim_busy[1]), 0);

      cyc(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
